// File: rtl/image_proc_pkg.sv
// Shared frame-buffer geometry and readout FSM encoding for the image pipeline.
// The UART-to-BRAM write stage imports the same FRAME_WORDS so both sides agree on frame size.
package image_proc_pkg;

    localparam int FRAME_WORDS     = 196608;
    localparam int FRAME_ADDR_W    = 18;
    localparam int PIXEL_W         = 24;
    localparam int BYTES_PER_PIXEL = 3;
    localparam int BYTE_IDX_W      = 2;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT_DATA,
        SEND,
        GUARD,
        DONE
    } readout_state_t;

    // Byte 0 is the MSB so bytes leave in the order the write stage received them.
    function automatic logic [7:0] pixel_byte(input logic [PIXEL_W-1:0] px,
                                              input logic [BYTE_IDX_W-1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = px[23:16];
            2'd1:    b = px[15:8];
            default: b = px[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/frame_readout_controller_if.sv
// BRAM read port, UART TX start/busy handshake and frame control/status of the readout stage.
// master = readout controller, slave = surrounding logic (BRAM, UART TX, sequencer).
interface frame_readout_controller_if
    import image_proc_pkg::*;
#(
    parameter int ADDR_W = FRAME_ADDR_W
);
    logic              start;
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [23:0]       dout;
    logic              tx_busy;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              busy;
    logic              done;

    modport master (
        input  start, dout, tx_busy,
        output en, addr, tx_start, tx_data, busy, done
    );

    modport slave (
        output start, dout, tx_busy,
        input  en, addr, tx_start, tx_data, busy, done
    );

endinterface

// File: rtl/pixel_byte_serializer.sv
// Holds one 24-bit pixel and walks it out MSB byte first; load restarts at byte 0.
// No latency of its own: byte_data and last_byte follow the registered pixel and index.
module pixel_byte_serializer
    import image_proc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               advance,
    input  logic [PIXEL_W-1:0] pixel,
    output logic [7:0]         byte_data,
    output logic               last_byte
);

    logic [PIXEL_W-1:0]    pixel_q;
    logic [BYTE_IDX_W-1:0] idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_q <= '0;
            idx_q   <= '0;
        end else if (load) begin
            pixel_q <= pixel;
            idx_q   <= '0;
        end else if (advance) begin
            idx_q <= idx_q + 2'd1;
        end
    end

    assign byte_data = pixel_byte(pixel_q, idx_q);
    assign last_byte = (idx_q == BYTE_IDX_W'(BYTES_PER_PIXEL - 1));

endmodule

// File: rtl/frame_readout_controller.sv
// Reads the frame buffer word 0..NUM_WORDS-1 and streams each word as 3 bytes to the UART TX.
// First tx_start 2+RD_LATENCY cycles after start; holds in SEND while tx_busy is high, no timeout.
module frame_readout_controller
    import image_proc_pkg::*;
#(
    parameter int NUM_WORDS  = FRAME_WORDS,
    parameter int ADDR_W     = FRAME_ADDR_W,
    parameter int RD_LATENCY = 2
)(
    input  logic                        clk,
    input  logic                        rst,
    frame_readout_controller_if.master  bus
);

    if (RD_LATENCY < 1 || RD_LATENCY > 2) begin : g_bad_latency
        $error("frame_readout_controller: RD_LATENCY must be 1 or 2");
    end
    if (NUM_WORDS < 1 || NUM_WORDS > (1 << ADDR_W)) begin : g_bad_words
        $error("frame_readout_controller: NUM_WORDS does not fit ADDR_W");
    end

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [1:0]        LAT_LAST  = 2'(RD_LATENCY - 1);

    readout_state_t    state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        lat_q, lat_d;

    logic       en_c;
    logic       tx_start_c;
    logic       done_c;
    logic       load;
    logic       advance;
    logic [7:0] ser_byte;
    logic       last_byte;
    logic       last_word;

    assign last_word = (addr_q == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        lat_d      = lat_q;
        en_c       = 1'b0;
        tx_start_c = 1'b0;
        done_c     = 1'b0;
        load       = 1'b0;
        advance    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = READ;
                end
            end
            READ: begin
                en_c    = 1'b1;
                lat_d   = '0;
                state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                lat_d = lat_q + 2'd1;
                if (lat_q == LAT_LAST) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (!bus.tx_busy) begin
                    tx_start_c = 1'b1;
                    state_d    = GUARD;
                end
            end
            // Gives tx_busy its one cycle to rise before the next byte is offered.
            GUARD: begin
                if (!last_byte) begin
                    advance = 1'b1;
                    state_d = SEND;
                end else if (last_word) begin
                    addr_d  = '0;
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = READ;
                end
            end
            DONE: begin
                done_c  = 1'b1;
                addr_d  = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    pixel_byte_serializer u_serializer (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .advance   (advance),
        .pixel     (bus.dout),
        .byte_data (ser_byte),
        .last_byte (last_byte)
    );

    assign bus.en       = en_c;
    assign bus.addr     = addr_q;
    assign bus.tx_start = tx_start_c;
    assign bus.tx_data  = (state_q == SEND) ? ser_byte : 8'h00;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_c;

endmodule

// File: tb/tb_frame_readout_controller.sv
// Three controller instances: [0] 4 words RD_LATENCY=2, [1] 4 words RD_LATENCY=1, [2] 1 word RD_LATENCY=2.
// Each has a BRAM model of matching latency and a UART model busy for 10 cycles per byte.
module tb_frame_readout_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s   [3];
    logic        start_s [3];
    logic        hold_s  [3];
    logic        hold_q  [3] = '{default: 1'b0};
    logic        busy_in [3];
    logic        en_o    [3];
    logic        tx_start_o [3];
    logic        busy_o  [3];
    logic        done_o  [3];
    logic [17:0] addr_o  [3];
    logic [7:0]  tx_data_o [3];
    logic [23:0] r1 [3] = '{default: 24'h0};
    logic [23:0] r2 [3] = '{default: 24'h0};
    int          busy_cnt [3] = '{default: 0};

    logic [23:0] mem [4]    = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
    logic [7:0]  exp_b [12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                                8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};

    logic [7:0]  byte_log    [3][256];
    int          tx_cyc_log  [3][256];
    logic [17:0] en_addr_log [3][64];
    int          en_cyc_log  [3][64];
    int          byte_cnt [3] = '{default: 0};
    int          en_cnt   [3] = '{default: 0};
    int          done_cnt [3] = '{default: 0};
    int          viol_cnt [3] = '{default: 0};

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NW = (g == 2) ? 1 : 4;
        localparam int RL = (g == 1) ? 1 : 2;

        frame_readout_controller_if #(.ADDR_W(18)) bus ();

        frame_readout_controller #(
            .NUM_WORDS (NW),
            .ADDR_W    (18),
            .RD_LATENCY(RL)
        ) dut (
            .clk (clk),
            .rst (rst_s[g]),
            .bus (bus.master)
        );

        assign busy_in[g]    = hold_q[g] | (busy_cnt[g] != 0);
        assign bus.start     = start_s[g];
        assign bus.tx_busy   = busy_in[g];
        assign bus.dout      = (RL == 1) ? r1[g] : r2[g];
        assign en_o[g]       = bus.en;
        assign addr_o[g]     = bus.addr;
        assign tx_start_o[g] = bus.tx_start;
        assign tx_data_o[g]  = bus.tx_data;
        assign busy_o[g]     = bus.busy;
        assign done_o[g]     = bus.done;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM and UART models; UART busy rises the cycle after tx_start.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (en_o[i]) r1[i] <= mem[addr_o[i][1:0]];
            r2[i]     <= r1[i];
            hold_q[i] <= hold_s[i];
            if (tx_start_o[i])         busy_cnt[i] <= 10;
            else if (busy_cnt[i] != 0) busy_cnt[i] <= busy_cnt[i] - 1;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (tx_start_o[i]) begin
                if (busy_in[i]) viol_cnt[i] = viol_cnt[i] + 1;
                if (byte_cnt[i] < 256) begin
                    byte_log[i][byte_cnt[i]]   = tx_data_o[i];
                    tx_cyc_log[i][byte_cnt[i]] = cyc;
                end
                byte_cnt[i] = byte_cnt[i] + 1;
            end
            if (en_o[i]) begin
                if (en_cnt[i] < 64) begin
                    en_addr_log[i][en_cnt[i]] = addr_o[i];
                    en_cyc_log[i][en_cnt[i]]  = cyc;
                end
                en_cnt[i] = en_cnt[i] + 1;
            end
            if (done_o[i]) done_cnt[i] = done_cnt[i] + 1;
        end
    end

    task automatic pulse_start(input int i, output int k);
        @(negedge clk);
        start_s[i] = 1'b1;
        k = cyc;
        @(negedge clk);
        start_s[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int target);
        int t = 0;
        while (done_cnt[i] < target && t < 3000) begin
            @(posedge clk);
            t++;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            rst_s[i] = 1'b1; start_s[i] = 1'b0; hold_s[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({en_o[i], addr_o[i], tx_start_o[i], tx_data_o[i], busy_o[i], done_o[i]} !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got en=%b addr=%0h tx_start=%b tx_data=%0h busy=%b done=%b, expected all 0",
                         i, en_o[i], addr_o[i], tx_start_o[i], tx_data_o[i], busy_o[i], done_o[i]);
            end
        end
        for (int i = 0; i < 3; i++) rst_s[i] = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy_o[0] !== 1'b0 || en_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_without_start: got busy=%b en=%b, expected 0 0", busy_o[0], en_o[0]);
        end
    endtask

    task automatic test_basic_frame();
        int k;
        int b0 = byte_cnt[0], e0 = en_cnt[0], d0 = done_cnt[0];
        pulse_start(0, k);
        wait_done(0, d0 + 1);
        @(negedge clk);
        n_checks++;
        if (busy_o[0] !== 1'b0) begin
            n_fail++; $display("FAIL basic_busy_after_done: got %b expected 0", busy_o[0]);
        end
        n_checks++;
        if (done_cnt[0] - d0 !== 1) begin
            n_fail++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt[0] - d0);
        end
        n_checks++;
        if (byte_cnt[0] - b0 !== 12) begin
            n_fail++; $display("FAIL basic_byte_count: got %0d expected 12", byte_cnt[0] - b0);
        end
        for (int j = 0; j < 12; j++) begin
            n_checks++;
            if (byte_log[0][b0 + j] !== exp_b[j]) begin
                n_fail++; $display("FAIL basic_byte[%0d]: got %0h expected %0h", j, byte_log[0][b0 + j], exp_b[j]);
            end
        end
        n_checks++;
        if (en_cnt[0] - e0 !== 4) begin
            n_fail++; $display("FAIL basic_en_count: got %0d expected 4", en_cnt[0] - e0);
        end
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (en_addr_log[0][e0 + j] !== 18'(j)) begin
                n_fail++; $display("FAIL basic_en_addr[%0d]: got %0d expected %0d", j, en_addr_log[0][e0 + j], j);
            end
        end
        n_checks++;
        if (en_cyc_log[0][e0] !== k + 1) begin
            n_fail++; $display("FAIL latency_en_rl2: got cycle %0d expected %0d", en_cyc_log[0][e0], k + 1);
        end
        n_checks++;
        if (tx_cyc_log[0][b0] !== k + 4) begin
            n_fail++; $display("FAIL latency_tx_rl2: got cycle %0d expected %0d", tx_cyc_log[0][b0], k + 4);
        end
    endtask

    task automatic test_latency_rl1();
        int k;
        int b0 = byte_cnt[1], e0 = en_cnt[1], d0 = done_cnt[1];
        pulse_start(1, k);
        wait_done(1, d0 + 1);
        repeat (2) @(negedge clk);
        n_checks++;
        if (en_cyc_log[1][e0] !== k + 1) begin
            n_fail++; $display("FAIL latency_en_rl1: got cycle %0d expected %0d", en_cyc_log[1][e0], k + 1);
        end
        n_checks++;
        if (tx_cyc_log[1][b0] !== k + 3) begin
            n_fail++; $display("FAIL latency_tx_rl1: got cycle %0d expected %0d", tx_cyc_log[1][b0], k + 3);
        end
        n_checks++;
        if (byte_cnt[1] - b0 !== 12 || done_cnt[1] - d0 !== 1) begin
            n_fail++; $display("FAIL rl1_counts: got bytes=%0d done=%0d expected 12 1", byte_cnt[1] - b0, done_cnt[1] - d0);
        end
        for (int j = 0; j < 12; j++) begin
            n_checks++;
            if (byte_log[1][b0 + j] !== exp_b[j]) begin
                n_fail++; $display("FAIL rl1_byte[%0d]: got %0h expected %0h", j, byte_log[1][b0 + j], exp_b[j]);
            end
        end
    endtask

    task automatic test_backpressure();
        int k, t, bad;
        int b0 = byte_cnt[0], d0 = done_cnt[0];
        pulse_start(0, k);
        t = 0;
        while (byte_cnt[0] < b0 + 5 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        hold_s[0] = 1'b1;
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (tx_start_o[0] !== 1'b0 || tx_data_o[0] !== 8'h66) bad++;
        end
        hold_s[0] = 1'b0;
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL backpressure_hold: got %0d bad cycles expected 0", bad);
        end
        @(negedge clk);
        n_checks++;
        if (tx_start_o[0] !== 1'b1 || tx_data_o[0] !== 8'h66) begin
            n_fail++; $display("FAIL backpressure_release: got tx_start=%b tx_data=%0h expected 1 66", tx_start_o[0], tx_data_o[0]);
        end
        wait_done(0, d0 + 1);
        repeat (2) @(negedge clk);
        n_checks++;
        if (byte_cnt[0] - b0 !== 12 || done_cnt[0] - d0 !== 1) begin
            n_fail++; $display("FAIL backpressure_counts: got bytes=%0d done=%0d expected 12 1", byte_cnt[0] - b0, done_cnt[0] - d0);
        end
        for (int j = 0; j < 12; j++) begin
            n_checks++;
            if (byte_log[0][b0 + j] !== exp_b[j]) begin
                n_fail++; $display("FAIL backpressure_byte[%0d]: got %0h expected %0h", j, byte_log[0][b0 + j], exp_b[j]);
            end
        end
        n_checks++;
        if (viol_cnt[0] !== 0) begin
            n_fail++; $display("FAIL tx_start_while_busy: got %0d expected 0", viol_cnt[0]);
        end
    endtask

    task automatic test_start_while_busy();
        int k, t;
        int b0 = byte_cnt[0], e0 = en_cnt[0], d0 = done_cnt[0];
        pulse_start(0, k);
        t = 0;
        while (byte_cnt[0] < b0 + 4 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        pulse_start(0, k);
        wait_done(0, d0 + 1);
        repeat (30) @(negedge clk);
        n_checks++;
        if (byte_cnt[0] - b0 !== 12 || done_cnt[0] - d0 !== 1 || en_cnt[0] - e0 !== 4) begin
            n_fail++;
            $display("FAIL start_while_busy_counts: got bytes=%0d done=%0d en=%0d expected 12 1 4",
                     byte_cnt[0] - b0, done_cnt[0] - d0, en_cnt[0] - e0);
        end
        n_checks++;
        if (busy_o[0] !== 1'b0) begin
            n_fail++; $display("FAIL start_while_busy_idle: got busy=%b expected 0", busy_o[0]);
        end
    endtask

    task automatic test_reset_midframe();
        int k, t, b1, d1;
        int b0 = byte_cnt[0], d0 = done_cnt[0];
        pulse_start(0, k);
        t = 0;
        while (byte_cnt[0] < b0 + 6 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (tx_data_o[0] !== 8'h77 && t < 50);
        n_checks++;
        if (tx_data_o[0] !== 8'h77) begin
            n_fail++; $display("FAIL midframe_reach_word2: got tx_data=%0h expected 77", tx_data_o[0]);
        end
        rst_s[0] = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({en_o[0], addr_o[0], tx_start_o[0], tx_data_o[0], busy_o[0], done_o[0]} !== 32'h0) begin
            n_fail++;
            $display("FAIL midframe_reset_outputs: got en=%b addr=%0h tx_start=%b tx_data=%0h busy=%b done=%b, expected all 0",
                     en_o[0], addr_o[0], tx_start_o[0], tx_data_o[0], busy_o[0], done_o[0]);
        end
        rst_s[0] = 1'b0;
        b1 = byte_cnt[0];
        d1 = done_cnt[0];
        n_checks++;
        if (d1 - d0 !== 0) begin
            n_fail++; $display("FAIL midframe_no_done: got %0d done pulses expected 0", d1 - d0);
        end
        pulse_start(0, k);
        wait_done(0, d1 + 1);
        repeat (2) @(negedge clk);
        n_checks++;
        if (byte_cnt[0] - b1 !== 12 || done_cnt[0] - d1 !== 1) begin
            n_fail++; $display("FAIL replay_counts: got bytes=%0d done=%0d expected 12 1", byte_cnt[0] - b1, done_cnt[0] - d1);
        end
        for (int j = 0; j < 12; j++) begin
            n_checks++;
            if (byte_log[0][b1 + j] !== exp_b[j]) begin
                n_fail++; $display("FAIL replay_byte[%0d]: got %0h expected %0h", j, byte_log[0][b1 + j], exp_b[j]);
            end
        end
    endtask

    task automatic test_single_word_back_to_back();
        int t;
        int b0 = byte_cnt[2], e0 = en_cnt[2], d0 = done_cnt[2];
        @(negedge clk);
        start_s[2] = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (done_o[2] !== 1'b1 && t < 500);
        n_checks++;
        if (byte_cnt[2] - b0 !== 3) begin
            n_fail++; $display("FAIL single_first_bytes: got %0d expected 3", byte_cnt[2] - b0);
        end
        @(negedge clk);
        n_checks++;
        if (busy_o[2] !== 1'b0 || en_o[2] !== 1'b0) begin
            n_fail++; $display("FAIL single_idle_gap: got busy=%b en=%b expected 0 0", busy_o[2], en_o[2]);
        end
        @(negedge clk);
        n_checks++;
        if (en_o[2] !== 1'b1 || addr_o[2] !== 18'd0) begin
            n_fail++; $display("FAIL single_restart: got en=%b addr=%0d expected 1 0", en_o[2], addr_o[2]);
        end
        start_s[2] = 1'b0;
        wait_done(2, d0 + 2);
        repeat (2) @(negedge clk);
        n_checks++;
        if (byte_cnt[2] - b0 !== 6 || done_cnt[2] - d0 !== 2 || en_cnt[2] - e0 !== 2) begin
            n_fail++;
            $display("FAIL single_counts: got bytes=%0d done=%0d en=%0d expected 6 2 2",
                     byte_cnt[2] - b0, done_cnt[2] - d0, en_cnt[2] - e0);
        end
        for (int j = 0; j < 6; j++) begin
            n_checks++;
            if (byte_log[2][b0 + j] !== exp_b[j % 3]) begin
                n_fail++; $display("FAIL single_byte[%0d]: got %0h expected %0h", j, byte_log[2][b0 + j], exp_b[j % 3]);
            end
        end
        n_checks++;
        if (viol_cnt[1] + viol_cnt[2] !== 0) begin
            n_fail++; $display("FAIL tx_start_while_busy_other: got %0d expected 0", viol_cnt[1] + viol_cnt[2]);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_latency_rl1();
        test_backpressure();
        test_start_while_busy();
        test_reset_midframe();
        test_single_word_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_readout_controller.md
Name: frame_readout_controller

Overview:
Downstream counterpart of the UART-to-BRAM write stage. On a start pulse it reads the frame buffer sequentially from word 0 to NUM_WORDS-1. Each 24-bit word is serialised into 3 bytes, MSB first, so bytes leave in the same order the write stage received them. Bytes go to the UART transmitter through a start/busy handshake. It shares the BRAM read port (en, addr, dout) and drives uart_tx directly.

Parameters:
NUM_WORDS, 196608, number of 24-bit words in one frame
ADDR_W, 18, BRAM address width
RD_LATENCY, 2, BRAM read latency in cycles (1 or 2 supported)

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  begin readout; sampled only in IDLE
en  out  1  BRAM port enable, read-only port (no we driven)
addr  out  ADDR_W  BRAM word address
dout  in  24  BRAM read data
tx_busy  in  1  UART TX busy; rises the cycle after tx_start and stays high until the byte is sent
tx_start  out  1  one-cycle request to transmit tx_data
tx_data  out  8  byte to transmit; held stable while tx_start high
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse after the last byte of the frame is handed off

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. While rst is high: state IDLE, addr=0, pixel register=0, byte index=0, latency counter=0, and en, tx_start, tx_data, busy, done all 0.
- Reset mid-frame aborts the frame immediately. No partial word is resumed. The next start begins again at word 0.
- States:
  - IDLE
    - All outputs low.
    - If start is high at edge k, go to READ.
    - start in any other state is ignored.
  - READ
    - One cycle with en=1 and addr=current word.
    - Next state is WAIT_DATA; latency counter cleared.
  - WAIT_DATA
    - Stays RD_LATENCY cycles; en=0.
    - On the edge ending the last cycle, dout is latched into the 24-bit pixel register and byte index is set to 0.
    - Next state is SEND.
  - SEND
    - tx_data = pixel[23:16], pixel[15:8] or pixel[7:0] for byte index 0, 1 or 2.
    - If tx_busy is low, tx_start=1 for this cycle only, then go to GUARD.
    - If tx_busy is high, stay in SEND with tx_start=0. Wait is unbounded, no timeout.
  - GUARD
    - One cycle, tx_start=0. This covers the one-cycle tx_busy rise latency.
    - If byte index is below 2: increment it and return to SEND.
    - If byte index is 2 and addr = NUM_WORDS-1: go to DONE.
    - If byte index is 2 otherwise: addr increments by 1 and the state returns to READ.
  - DONE
    - One cycle with done=1 and addr reset to 0.
    - Next state is IDLE; busy drops in the IDLE cycle.
- Latency: with start at edge k and tx idle, READ occupies cycle k+1. The first tx_start is in cycle k+2+RD_LATENCY.
- Per-word throughput is bounded by the UART. Controller overhead is 1+RD_LATENCY cycles per word plus 1 GUARD cycle per byte.
- addr never exceeds NUM_WORDS-1, so no wrap-around. NUM_WORDS=1 is legal: READ, 3 bytes, then DONE.
- start held high continuously: after DONE the block returns to IDLE and restarts on the next edge. This is a legal back-to-back frame.
- tx_busy already high on entry to SEND: hold in SEND. Never pulse tx_start while tx_busy is high.

Decomposition:
- Package image_proc_pkg:
  - readout state enum (IDLE, READ, WAIT_DATA, SEND, GUARD, DONE)
  - BYTES_PER_PIXEL=3
  - FRAME_WORDS=196608
  - FRAME_ADDR_W=18
  - the write stage imports the same FRAME_WORDS.
- One natural sub-module, pixel_byte_serializer:
  - holds the pixel register and byte index, and muxes tx_data
  - inputs: load, advance, 24-bit pixel
  - output: last_byte flag
- The FSM and address counter stay in the top module.

Test Plan:
- Basic frame, NUM_WORDS=4, RD_LATENCY=2, BRAM preloaded {0x112233, 0x445566, 0x778899, 0xAABBCC}, tx_busy modelled as 10 cycles after each tx_start, pulse start → exactly 12 tx_start pulses carrying bytes 11,22,33,44,...,CC in order. en is high on 4 cycles with addr 0,1,2,3; one done pulse; busy then low.
- Latency check, start at edge k with tx idle → en high in cycle k+1 and first tx_start in cycle k+4. Repeat with RD_LATENCY=1 and BRAM model latency 1 → first tx_start in cycle k+3 and data still correct.
- Backpressure, hold tx_busy high for 50 cycles at the start of byte 2 of word 1 → tx_start stays 0 throughout, tx_data is stable at 0x66, and the byte is sent on the first low cycle. No bytes lost or duplicated.
- Start while busy, pulse start mid-frame → ignored. Still exactly 3·NUM_WORDS bytes and one done.
- Reset mid-frame, assert rst during SEND of word 2 → next cycle all outputs 0 and addr=0. A new start then replays the frame from 0x11 with a full byte count.
- NUM_WORDS=1 and start held high → 3 bytes, done, IDLE for one cycle, then automatic restart at addr 0.
